// File: rtl/channel.sv
// channel: single-slot clocked CSP channel carrying one WIDTH-bit token from a
// sender to a receiver over bundled-data handshakes (four-phase or two-phase).
module channel #(
  parameter int WIDTH       = 64,
  parameter int HS_PROTOCOL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             full,
  output logic [15:0]      xfer_cnt,
  output logic             proto_err
);

  localparam bit TWO_PHASE = (HS_PROTOCOL == 1);

  typedef enum logic {SND_IDLE, SND_ACKED} snd_state_e;
  typedef enum logic [1:0] {RCV_IDLE, RCV_OFFER, RCV_RELEASE} rcv_state_e;

  snd_state_e       snd_state_q, snd_state_d;
  rcv_state_e       rcv_state_q, rcv_state_d;
  logic             s_ack_q, s_ack_d;
  logic             r_req_q, r_req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic             full_set, full_clr, snd_err, rcv_err;

  // Sender side: capture a pending request into the buffer only when it is empty.
  always_comb begin
    snd_state_d = snd_state_q;
    s_ack_d     = s_ack_q;
    data_d      = data_q;
    pend_d      = pend_q;
    full_set    = 1'b0;
    snd_err     = 1'b0;
    if (TWO_PHASE) begin
      snd_state_d = SND_IDLE;
      pend_d      = 1'b0;
      if ((s_req != s_ack_q) && !full_q) begin
        s_ack_d  = ~s_ack_q;
        data_d   = s_data;
        full_set = 1'b1;
      end
    end else begin
      case (snd_state_q)
        SND_IDLE: begin
          if (s_req) begin
            if (!full_q) begin
              data_d      = s_data;
              s_ack_d     = 1'b1;
              full_set    = 1'b1;
              pend_d      = 1'b0;
              snd_state_d = SND_ACKED;
            end else begin
              pend_d = 1'b1;
            end
          end else begin
            if (pend_q) snd_err = 1'b1;
            pend_d = 1'b0;
          end
        end
        SND_ACKED: begin
          if (!s_req) begin
            s_ack_d     = 1'b0;
            snd_state_d = SND_IDLE;
          end
        end
        default: snd_state_d = SND_IDLE;
      endcase
    end
  end

  // Receiver side: offer the buffered token and retire it on acknowledge.
  always_comb begin
    rcv_state_d = rcv_state_q;
    r_req_d     = r_req_q;
    cnt_d       = cnt_q;
    full_clr    = 1'b0;
    rcv_err     = 1'b0;
    if (TWO_PHASE) begin
      case (rcv_state_q)
        RCV_IDLE: begin
          if (r_ack != r_req_q) rcv_err = 1'b1;
          if (full_q) begin
            r_req_d     = ~r_req_q;
            rcv_state_d = RCV_OFFER;
          end
        end
        RCV_OFFER: begin
          if (r_ack == r_req_q) begin
            full_clr    = 1'b1;
            cnt_d       = cnt_q + 16'd1;
            rcv_state_d = RCV_IDLE;
          end
        end
        default: rcv_state_d = RCV_IDLE;
      endcase
    end else begin
      case (rcv_state_q)
        RCV_IDLE: begin
          if (r_ack) rcv_err = 1'b1;
          if (full_q) begin
            r_req_d     = 1'b1;
            rcv_state_d = RCV_OFFER;
          end
        end
        RCV_OFFER: begin
          if (r_ack) begin
            r_req_d     = 1'b0;
            full_clr    = 1'b1;
            cnt_d       = cnt_q + 16'd1;
            rcv_state_d = RCV_RELEASE;
          end
        end
        RCV_RELEASE: begin
          if (!r_ack) rcv_state_d = RCV_IDLE;
        end
        default: rcv_state_d = RCV_IDLE;
      endcase
    end
  end

  // Buffer occupancy and sticky error; set and clear can never coincide.
  always_comb begin
    full_d = full_q;
    if (full_set) full_d = 1'b1;
    else if (full_clr) full_d = 1'b0;
    err_d = err_q | snd_err | rcv_err;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      snd_state_q <= SND_IDLE;
      rcv_state_q <= RCV_IDLE;
      s_ack_q     <= 1'b0;
      r_req_q     <= 1'b0;
      data_q      <= '0;
      full_q      <= 1'b0;
      cnt_q       <= 16'd0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      snd_state_q <= snd_state_d;
      rcv_state_q <= rcv_state_d;
      s_ack_q     <= s_ack_d;
      r_req_q     <= r_req_d;
      data_q      <= data_d;
      full_q      <= full_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
    end
  end

  assign s_ack     = s_ack_q;
  assign r_req     = r_req_q;
  assign r_data    = data_q;
  assign full      = full_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_channel.sv
// tb_channel: exercises a four-phase and a two-phase channel against a
// token-queue reference model and fixed handshake latencies.
module tb_channel;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_req4, r_ack4, s_ack4, r_req4, full4, err4;
  logic [63:0] s_data4, r_data4;
  logic [15:0] cnt4;

  logic        s_req2, r_ack2, s_ack2, r_req2, full2, err2;
  logic [63:0] s_data2, r_data2;
  logic [15:0] cnt2;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_q2[$];
  int          delivered;

  int   ack2_toggles = 0;
  int   req2_toggles = 0;
  logic prev_ack2 = 1'b0;
  logic prev_req2 = 1'b0;

  always #5 clk = ~clk;

  channel #(.WIDTH(64), .HS_PROTOCOL(0)) dut4 (
    .clk(clk), .rst(rst), .s_req(s_req4), .s_data(s_data4), .s_ack(s_ack4),
    .r_req(r_req4), .r_data(r_data4), .r_ack(r_ack4), .full(full4),
    .xfer_cnt(cnt4), .proto_err(err4)
  );

  channel #(.WIDTH(64), .HS_PROTOCOL(1)) dut2 (
    .clk(clk), .rst(rst), .s_req(s_req2), .s_data(s_data2), .s_ack(s_ack2),
    .r_req(r_req2), .r_data(r_data2), .r_ack(r_ack2), .full(full2),
    .xfer_cnt(cnt2), .proto_err(err2)
  );

  // Count every transition of the two-phase handshake outputs.
  always @(negedge clk) begin
    if (s_ack2 !== prev_ack2) ack2_toggles <= ack2_toggles + 1;
    if (r_req2 !== prev_req2) req2_toggles <= req2_toggles + 1;
    prev_ack2 <= s_ack2;
    prev_req2 <= r_req2;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_s_ack"}, s_ack4, 0);
    checkOutput({tag, "_r_req"}, r_req4, 0);
    checkOutput({tag, "_r_data"}, r_data4, 0);
    checkOutput({tag, "_full"}, full4, 0);
    checkOutput({tag, "_cnt"}, cnt4, 0);
    checkOutput({tag, "_err"}, err4, 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    s_req4 = 1'b0; r_ack4 = 1'b0; s_data4 = '0;
    s_req2 = 1'b0; r_ack2 = 1'b0; s_data2 = '0;
    tick();
    tick();
    checkIdle("reset");
    rst = 1'b0;
  endtask

  // Random-delay four-phase stream of n tokens checked against the token queue.
  task automatic applyStimulus(input int n);
    delivered = 0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int d;
          int w;
          d = $urandom_range(0, 5);
          repeat (d) tick();
          s_data4 = 64'(i);
          exp_q.push_back(64'(i));
          s_req4 = 1'b1;
          w = 0;
          while (s_ack4 !== 1'b1 && w < 200) begin tick(); w++; end
          checkOutput("stream_s_ack_rise", s_ack4, 1);
          s_req4 = 1'b0;
          w = 0;
          while (s_ack4 !== 1'b0 && w < 200) begin tick(); w++; end
          checkOutput("stream_s_ack_fall", s_ack4, 0);
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          int d;
          int w;
          w = 0;
          while (r_req4 !== 1'b1 && w < 200) begin tick(); w++; end
          checkOutput("stream_r_req_rise", r_req4, 1);
          d = $urandom_range(0, 5);
          repeat (d) tick();
          if (exp_q.size() == 0) checkOutput("stream_unexpected_token", r_data4, 64'hFFFF_FFFF_FFFF_FFFF);
          else checkOutput("stream_data", r_data4, exp_q.pop_front());
          r_ack4 = 1'b1;
          w = 0;
          while (r_req4 !== 1'b0 && w < 200) begin tick(); w++; end
          checkOutput("stream_r_req_fall", r_req4, 0);
          delivered++;
          checkOutput("stream_cnt", cnt4, 64'(delivered & 16'hFFFF));
          r_ack4 = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyReset();

    // Single token with immediate partners.
    s_data4 = 64'hDEAD_BEEF_0000_0001;
    s_req4 = 1'b1;
    tick();
    checkOutput("t1_s_ack", s_ack4, 1);
    checkOutput("t1_full", full4, 1);
    checkOutput("t1_r_req_early", r_req4, 0);
    s_req4 = 1'b0;
    tick();
    checkOutput("t1_r_req", r_req4, 1);
    checkOutput("t1_s_ack_low", s_ack4, 0);
    checkOutput("t1_r_data", r_data4, 64'hDEAD_BEEF_0000_0001);
    r_ack4 = 1'b1;
    tick();
    checkOutput("t1_r_req_low", r_req4, 0);
    checkOutput("t1_full_low", full4, 0);
    checkOutput("t1_cnt", cnt4, 1);
    r_ack4 = 1'b0;
    tick();
    checkOutput("t1_err", err4, 0);

    // Backpressure: second token waits until the buffer drains.
    s_data4 = 64'h1111;
    s_req4 = 1'b1;
    tick();
    s_req4 = 1'b0;
    tick();
    s_data4 = 64'h2;
    s_req4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_s_ack", s_ack4, 0);
      checkOutput("bp_r_data", r_data4, 64'h1111);
    end
    r_ack4 = 1'b1;
    tick();
    checkOutput("bp_full_drop", full4, 0);
    checkOutput("bp_no_merge", s_ack4, 0);
    r_ack4 = 1'b0;
    tick();
    checkOutput("bp_capture", s_ack4, 1);
    checkOutput("bp_r_data2", r_data4, 64'h2);
    checkOutput("bp_full2", full4, 1);
    s_req4 = 1'b0;
    tick();
    checkOutput("bp_offer2", r_req4, 1);
    r_ack4 = 1'b1;
    tick();
    r_ack4 = 1'b0;
    tick();
    checkOutput("bp_cnt", cnt4, 3);
    checkOutput("bp_err", err4, 0);

    // Random-delay stream of 20 tokens.
    applyReset();
    applyStimulus(20);
    checkOutput("stream_total", cnt4, 20);
    checkOutput("stream_leftover", 64'(exp_q.size()), 0);
    checkOutput("stream_err", err4, 0);

    // Acknowledge with no offer outstanding; sticky until reset.
    applyReset();
    r_ack4 = 1'b1;
    tick();
    checkOutput("pe_rack_idle", err4, 1);
    r_ack4 = 1'b0;
    s_data4 = 64'h77;
    s_req4 = 1'b1;
    tick();
    s_req4 = 1'b0;
    tick();
    checkOutput("pe_traffic_data", r_data4, 64'h77);
    r_ack4 = 1'b1;
    tick();
    r_ack4 = 1'b0;
    tick();
    checkOutput("pe_sticky", err4, 1);
    checkOutput("pe_traffic_cnt", cnt4, 1);
    applyReset();

    // Withdrawn request while backpressured.
    s_data4 = 64'h33;
    s_req4 = 1'b1;
    tick();
    s_req4 = 1'b0;
    tick();
    s_req4 = 1'b1;
    tick();
    checkOutput("pe_wait_ok", err4, 0);
    s_req4 = 1'b0;
    tick();
    checkOutput("pe_withdraw", err4, 1);
    applyReset();

    // Reset while an offer is outstanding.
    s_data4 = 64'hAB;
    s_req4 = 1'b1;
    tick();
    s_req4 = 1'b0;
    tick();
    checkOutput("mr_offer", r_req4, 1);
    rst = 1'b1;
    tick();
    checkIdle("mr");
    rst = 1'b0;
    s_data4 = 64'h55;
    s_req4 = 1'b1;
    tick();
    checkOutput("mr_s_ack", s_ack4, 1);
    s_req4 = 1'b0;
    tick();
    checkOutput("mr_r_req", r_req4, 1);
    checkOutput("mr_r_data", r_data4, 64'h55);
    r_ack4 = 1'b1;
    tick();
    checkOutput("mr_cnt", cnt4, 1);
    checkOutput("mr_full", full4, 0);
    r_ack4 = 1'b0;
    tick();

    // Two-phase: three random tokens via transitions.
    applyReset();
    for (int k = 0; k < 3; k++) begin
      logic [63:0] tok;
      int d;
      tok = {$urandom, $urandom};
      exp_q2.push_back(tok);
      s_data2 = tok;
      s_req2 = ~s_req2;
      tick();
      checkOutput("p2_s_ack", s_ack2, 64'(s_req2));
      checkOutput("p2_full", full2, 1);
      tick();
      checkOutput("p2_offer", r_req2 ^ r_ack2, 1);
      checkOutput("p2_data", r_data2, exp_q2.pop_front());
      d = $urandom_range(0, 3);
      repeat (d) tick();
      r_ack2 = r_req2;
      tick();
      checkOutput("p2_full_low", full2, 0);
      checkOutput("p2_cnt", cnt2, 64'(k + 1));
    end
    checkOutput("p2_ack_toggles", 64'(ack2_toggles), 3);
    checkOutput("p2_req_toggles", 64'(req2_toggles), 3);
    checkOutput("p2_err_clean", err2, 0);
    r_ack2 = ~r_ack2;
    tick();
    checkOutput("p2_err_stray_ack", err2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
